spi_tx_scheduler: RTL and testbench

- Sequences the tracking-coordinate payload handed to the SPI slave.
- Accepts per-frame detection results from the vision pipeline and keeps the latest result.
- On the slave's `req`, freezes one coherent snapshot onto `xdata_tx`/`ydata_tx`. The snapshot stays stable until chip-select deasserts or a watchdog expires.
- Adds sequence, age and freshness metadata, and reports transaction and error status to the rest of the design.

---
 rtl/spi_sched_pkg.sv | 48 ++++
 rtl/spi_tx_scheduler_sync2.sv | 20 ++
 rtl/spi_tx_scheduler.sv | 149 ++++++++++++++
 tb/tb_spi_tx_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sched_pkg.sv
// Shared types and helpers for the SPI transmit scheduler: FSM states, the
// coordinate record kept for the latest frame and the frozen snapshot, and word packing.
package spi_sched_pkg;

    localparam int unsigned WORD_W      = 16;
    localparam int unsigned MAX_COORD_W = 14;
    localparam int unsigned MAX_MW      = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    // Fields are sized for the widest legal configuration; unused upper bits stay zero.
    typedef struct packed {
        logic                   found;
        logic [MAX_MW-1:0]      seq;
        logic [MAX_MW-1:0]      age;
        logic [MAX_COORD_W-1:0] x;
        logic [MAX_COORD_W-1:0] y;
    } coord_rec_t;

    function automatic int unsigned meta_w(input int unsigned coord_w);
        return 15 - coord_w;
    endfunction

    function automatic logic [WORD_W-1:0] pack_word(input logic                   flag,
                                                    input logic [MAX_MW-1:0]      meta,
                                                    input logic [MAX_COORD_W-1:0] coord,
                                                    input int unsigned            coord_w);
        logic [WORD_W-2:0] coord_mask;
        logic [WORD_W-2:0] body;
        coord_mask = ((WORD_W-1)'(1) << coord_w) - (WORD_W-1)'(1);
        body       = ((WORD_W-1)'(meta) << coord_w) | ((WORD_W-1)'(coord) & coord_mask);
        return {flag, body};
    endfunction

    function automatic logic [WORD_W-1:0] pack_x(input coord_rec_t rec, input int unsigned coord_w);
        return pack_word(rec.found, rec.seq, rec.x, coord_w);
    endfunction

    function automatic logic [WORD_W-1:0] pack_y(input coord_rec_t rec, input logic fresh,
                                                 input int unsigned coord_w);
        return pack_word(fresh, rec.age, rec.y, coord_w);
    endfunction

endpackage

// File: rtl/spi_tx_scheduler_sync2.sv
// Two-flop synchronizer for a single asynchronous level, with a selectable reset value.
module sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= {2{RESET_VAL}};
        else       sync_q <= {sync_q[0], d_i};
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/spi_tx_scheduler.sv
// Keeps the latest vision result and freezes a coherent snapshot for the SPI slave on
// each request, holding it until chip-select deasserts or the watchdog aborts.
module spi_tx_scheduler
    import spi_sched_pkg::*;
#(
    parameter int unsigned COORD_W     = 10,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               coord_valid,
    input  logic               coord_found,
    input  logic [COORD_W-1:0] coord_x,
    input  logic [COORD_W-1:0] coord_y,
    input  logic               spi_req,
    input  logic               spi_cs,
    output logic [15:0]        xdata_tx,
    output logic [15:0]        ydata_tx,
    output logic               busy,
    output logic               timeout_err,
    output logic [15:0]        txn_count
);

    localparam int unsigned       MW       = meta_w(COORD_W);
    localparam logic [MAX_MW-1:0] META_MAX = MAX_MW'((1 << MW) - 1);
    localparam int unsigned       WD_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0]   WD_LAST  = WD_W'(TIMEOUT_CYC - 1);

    logic       cs_hi;
    logic       req_d_q;
    logic       req_rise;
    state_t     state_q, state_d;
    coord_rec_t latest_q, latest_d;
    coord_rec_t snap_q, snap_d;
    logic       latest_sent_q, latest_sent_d;
    logic       fresh_q, fresh_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic       timeout_q, timeout_d;
    logic [15:0] txn_q, txn_d;
    logic       load_snap, wd_run, abort, complete;

    sync2 #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (spi_cs),
        .q_o   (cs_hi)
    );

    assign req_rise = spi_req & ~req_d_q;

    // NOTE: clocked state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: each combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (req_rise) state_d = ST_BUSY;
            ST_BUSY: begin
                if (cs_hi)                 state_d = ST_DONE;
                else if (wd_q == WD_LAST)  state_d = ST_IDLE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        load_snap = 1'b0;
        wd_run    = 1'b0;
        abort     = 1'b0;
        complete  = 1'b0;
        case (state_q)
            ST_IDLE: load_snap = req_rise;
            ST_BUSY: begin
                wd_run = 1'b1;
                abort  = ~cs_hi & (wd_q == WD_LAST);
            end
            ST_DONE: complete = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        latest_d      = latest_q;
        latest_sent_d = latest_sent_q;
        if (coord_valid) begin
            latest_d.found = coord_found;
            latest_d.x     = MAX_COORD_W'(coord_x);
            latest_d.y     = MAX_COORD_W'(coord_y);
            latest_d.seq   = (latest_q.seq + MAX_MW'(1)) & META_MAX;
            if (coord_found)                 latest_d.age = '0;
            else if (latest_q.age != META_MAX) latest_d.age = latest_q.age + MAX_MW'(1);
            latest_sent_d = 1'b0;
        end

        // A frame arriving on the load cycle is bypassed straight into the snapshot.
        snap_d  = snap_q;
        fresh_d = fresh_q;
        if (load_snap) begin
            snap_d        = latest_d;
            fresh_d       = ~latest_sent_d;
            latest_sent_d = 1'b1;
        end

        wd_d = wd_q;
        if (load_snap)   wd_d = '0;
        else if (wd_run) wd_d = wd_q + WD_W'(1);

        timeout_d = timeout_q;
        if (abort)         timeout_d = 1'b1;
        else if (complete) timeout_d = 1'b0;

        txn_d = complete ? txn_q + 16'd1 : txn_q;
    end

    // NOTE: the snapshot is a handful of flops, not a memory, so it is reset with everything else.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_d_q       <= 1'b0;
            latest_q      <= '0;
            latest_sent_q <= 1'b1;
            snap_q        <= '0;
            fresh_q       <= 1'b0;
            wd_q          <= '0;
            timeout_q     <= 1'b0;
            txn_q         <= '0;
        end else begin
            req_d_q       <= spi_req;
            latest_q      <= latest_d;
            latest_sent_q <= latest_sent_d;
            snap_q        <= snap_d;
            fresh_q       <= fresh_d;
            wd_q          <= wd_d;
            timeout_q     <= timeout_d;
            txn_q         <= txn_d;
        end
    end

    assign xdata_tx    = pack_x(snap_q, COORD_W);
    assign ydata_tx    = pack_y(snap_q, fresh_q, COORD_W);
    assign busy        = (state_q != ST_IDLE);
    assign timeout_err = timeout_q;
    assign txn_count   = txn_q;

endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Directed bench for spi_tx_scheduler: a vector table of frame/transaction records plus
// hand-written sequences for busy-time frames, watchdog abort and mid-transaction reset.
module tb_spi_tx_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        coord_valid;
    logic        coord_found;
    logic [9:0]  coord_x;
    logic [9:0]  coord_y;
    logic        spi_req;
    logic        spi_cs;
    logic [15:0] xdata_tx;
    logic [15:0] ydata_tx;
    logic        busy;
    logic        timeout_err;
    logic [15:0] txn_count;

    int n_pass  = 0;
    int n_total = 0;
    int exp_txn = 0;

    spi_tx_scheduler #(.COORD_W(10), .TIMEOUT_CYC(50)) dut (
        .clk         (clk),
        .reset       (reset),
        .coord_valid (coord_valid),
        .coord_found (coord_found),
        .coord_x     (coord_x),
        .coord_y     (coord_y),
        .spi_req     (spi_req),
        .spi_cs      (spi_cs),
        .xdata_tx    (xdata_tx),
        .ydata_tx    (ydata_tx),
        .busy        (busy),
        .timeout_err (timeout_err),
        .txn_count   (txn_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n_frames;
        logic        found;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        bypass;
        logic [15:0] exp_x;
        logic [15:0] exp_y;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic check_words(input string name, input logic [15:0] ex, input logic [15:0] ey);
        check({name, "_x"}, {16'h0, xdata_tx}, {16'h0, ex});
        check({name, "_y"}, {16'h0, ydata_tx}, {16'h0, ey});
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_frame(input logic f, input logic [9:0] x, input logic [9:0] y);
        coord_valid = 1'b1;
        coord_found = f;
        coord_x     = x;
        coord_y     = y;
        tick();
        coord_valid = 1'b0;
        tick();
    endtask

    // Lowers cs long enough for the synchronizer to settle, then raises req; returns
    // at the falling edge right after the load edge.
    task automatic start_txn(input logic bypass, input logic f, input logic [9:0] x,
                             input logic [9:0] y);
        spi_cs = 1'b0;
        tick();
        tick();
        tick();
        spi_req = 1'b1;
        if (bypass) begin
            coord_valid = 1'b1;
            coord_found = f;
            coord_x     = x;
            coord_y     = y;
        end
        tick();
        coord_valid = 1'b0;
        check("busy_after_load", {31'h0, busy}, 32'd1);
    endtask

    task automatic finish_txn(input string name, input logic [15:0] ex, input logic [15:0] ey);
        tick();
        tick();
        tick();
        spi_req = 1'b0;
        check_words({name, "_held"}, ex, ey);
        spi_cs = 1'b1;
        tick();
        tick();
        tick();
        check({name, "_busy_in_done"}, {31'h0, busy}, 32'd1);
        check({name, "_txn_before"}, {16'h0, txn_count}, 32'(exp_txn[15:0]));
        tick();
        exp_txn++;
        check({name, "_busy_low"}, {31'h0, busy}, 32'd0);
        check({name, "_txn_after"}, {16'h0, txn_count}, 32'(exp_txn[15:0]));
        check({name, "_tmo_clear"}, {31'h0, timeout_err}, 32'd0);
        check_words({name, "_after"}, ex, ey);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        vecs[0] = '{0,  1'b0, 10'd0,    10'd0,    1'b0, 16'h0000, 16'h0000};
        vecs[1] = '{1,  1'b1, 10'd320,  10'd240,  1'b0, 16'h8540, 16'h80F0};
        vecs[2] = '{3,  1'b0, 10'd100,  10'd200,  1'b0, 16'h1064, 16'h8CC8};
        vecs[3] = '{0,  1'b0, 10'd0,    10'd0,    1'b0, 16'h1064, 16'h0CC8};
        vecs[4] = '{0,  1'b1, 10'd5,    10'd7,    1'b1, 16'h9405, 16'h8007};
        vecs[5] = '{2,  1'b1, 10'd1023, 10'd1023, 1'b0, 16'h9FFF, 16'h83FF};
        vecs[6] = '{40, 1'b0, 10'd10,   10'd20,   1'b0, 16'h3C0A, 16'hFC14};

        reset       = 1'b1;
        coord_valid = 1'b0;
        coord_found = 1'b0;
        coord_x     = '0;
        coord_y     = '0;
        spi_req     = 1'b0;
        spi_cs      = 1'b1;
        #12;
        check_words("reset", 16'h0000, 16'h0000);
        check("reset_busy", {31'h0, busy}, 32'd0);
        check("reset_tmo", {31'h0, timeout_err}, 32'd0);
        check("reset_txn", {16'h0, txn_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            for (int f = 0; f < vecs[i].n_frames; f++)
                send_frame(vecs[i].found, vecs[i].x, vecs[i].y);
            start_txn(vecs[i].bypass, vecs[i].found, vecs[i].x, vecs[i].y);
            check_words($sformatf("vec%0d_load", i), vecs[i].exp_x, vecs[i].exp_y);
            finish_txn($sformatf("vec%0d", i), vecs[i].exp_x, vecs[i].exp_y);
            tick();
        end

        // Frame and a second req edge while BUSY must not disturb the frozen words.
        start_txn(1'b0, 1'b0, 10'd0, 10'd0);
        check_words("stale_load", 16'h3C0A, 16'h7C14);
        spi_req = 1'b0;
        tick();
        spi_req     = 1'b1;
        coord_valid = 1'b1;
        coord_found = 1'b1;
        coord_x     = 10'd11;
        coord_y     = 10'd22;
        tick();
        coord_valid = 1'b0;
        check_words("busy_frame", 16'h3C0A, 16'h7C14);
        finish_txn("busy_frame", 16'h3C0A, 16'h7C14);
        tick();
        start_txn(1'b0, 1'b0, 10'd0, 10'd0);
        check_words("post_busy_load", 16'hC00B, 16'h8016);
        finish_txn("post_busy", 16'hC00B, 16'h8016);
        tick();

        // Watchdog abort with cs held low: 50 cycles in BUSY.
        start_txn(1'b0, 1'b0, 10'd0, 10'd0);
        check_words("tmo_load", 16'hC00B, 16'h0016);
        for (int k = 1; k < 50; k++) begin
            tick();
            if (k == 3) spi_req = 1'b0;
        end
        check("tmo_busy_49", {31'h0, busy}, 32'd1);
        check("tmo_flag_49", {31'h0, timeout_err}, 32'd0);
        tick();
        check("tmo_busy_50", {31'h0, busy}, 32'd0);
        check("tmo_flag_50", {31'h0, timeout_err}, 32'd1);
        check("tmo_txn", {16'h0, txn_count}, 32'(exp_txn[15:0]));
        check_words("tmo_held", 16'hC00B, 16'h0016);
        tick();
        start_txn(1'b0, 1'b0, 10'd0, 10'd0);
        check("tmo_flag_during_clean", {31'h0, timeout_err}, 32'd1);
        finish_txn("tmo_clean", 16'hC00B, 16'h0016);
        tick();

        // Asynchronous reset in the middle of a transaction.
        send_frame(1'b1, 10'd3, 10'd4);
        start_txn(1'b0, 1'b0, 10'd0, 10'd0);
        check_words("rst_mid_load", 16'hC403, 16'h8004);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_words("rst_mid", 16'h0000, 16'h0000);
        check("rst_mid_busy", {31'h0, busy}, 32'd0);
        check("rst_mid_txn", {16'h0, txn_count}, 32'd0);
        spi_req = 1'b0;
        @(negedge clk);
        reset   = 1'b0;
        exp_txn = 0;
        tick();
        start_txn(1'b0, 1'b0, 10'd0, 10'd0);
        check_words("after_rst_load", 16'h0000, 16'h0000);
        finish_txn("after_rst", 16'h0000, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
